// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - SPI-side command/data RAM slave with burst addressing and tx backpressure
// Decodes 2-bit command prefix: write-addr, write-data, read-addr, read-data.
module spi_ram_burst #(
   parameter int DATA_W    = 8,
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8,
   parameter int AUTO_INC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [DATA_W+1:0] din,
   input  logic              tx_ready,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   output logic              busy,
   output logic              addr_err,
   output logic              rd_ovf
);

   localparam logic [1:0]        CMD_WR_ADDR = 2'b00;
   localparam logic [1:0]        CMD_WR_DATA = 2'b01;
   localparam logic [1:0]        CMD_RD_ADDR = 2'b10;
   localparam logic [1:0]        CMD_RD_DATA = 2'b11;
   // One extra bit so a full power-of-two depth is representable.
   localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C      = ADDR_W'(MEM_DEPTH - 1);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];

   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              tx_valid_q, tx_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              rd_ovf_q, rd_ovf_d;

   logic [1:0]        cmd;
   logic [DATA_W-1:0] payload;
   logic [ADDR_W-1:0] addr_in;
   logic              addr_ok;
   logic              tx_free;
   logic              rd_issue;
   logic              wr_en;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      if (AUTO_INC == 0) begin
         return a;
      end
      return (a == LAST_C) ? '0 : a + ADDR_W'(1);
   endfunction

   assign cmd     = din[DATA_W+1:DATA_W];
   assign payload = din[DATA_W-1:0];
   assign addr_in = din[ADDR_W-1:0];
   assign addr_ok = ({1'b0, addr_in} < DEPTH_C);
   // The slot frees up in the same cycle it is accepted, allowing back-to-back reads.
   assign tx_free = ~tx_valid_q | tx_ready;

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      tx_valid_d = tx_valid_q;
      addr_err_d = 1'b0;
      rd_ovf_d   = 1'b0;
      rd_issue   = 1'b0;
      wr_en      = 1'b0;

      if (tx_valid_q && tx_ready) begin
         tx_valid_d = 1'b0;
      end

      if (rx_valid) begin
         case (cmd)
            CMD_WR_ADDR: begin
               if (addr_ok) wr_addr_d = addr_in;
               else         addr_err_d = 1'b1;
            end
            CMD_WR_DATA: begin
               wr_en     = 1'b1;
               wr_addr_d = next_addr(wr_addr_q);
            end
            CMD_RD_ADDR: begin
               if (addr_ok) rd_addr_d = addr_in;
               else         addr_err_d = 1'b1;
            end
            CMD_RD_DATA: begin
               if (tx_free) begin
                  rd_issue = 1'b1;
                  rd_addr_d = next_addr(rd_addr_q);
               end else begin
                  rd_ovf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (rd_issue) begin
         dout_d     = mem_q[rd_addr_q];
         tx_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr_q] <= payload;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
         rd_ovf_q   <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         addr_err_q <= addr_err_d;
         rd_ovf_q   <= rd_ovf_d;
      end
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign busy     = tx_valid_q & ~tx_ready;
   assign addr_err = addr_err_q;
   assign rd_ovf   = rd_ovf_q;

endmodule
